// File: rtl/dmem_port_arbiter.sv
// Arbiter that shares the single-port data RAM between the host loader path and the core data port.
// Optional feature: define DMEM_ARB_RR_EN for round-robin conflict resolution (default: fixed core priority).
module dmem_port_arbiter #(
  parameter int AW       = 4,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [31:0]   i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [31:0]   o_host_rdata,
  input  logic          i_core_req,
  input  logic          i_core_we,
  input  logic [3:0]    i_core_be,
  input  logic [AW-1:0] i_core_addr,
  input  logic [31:0]   i_core_wdata,
  output logic          o_core_gnt,
  output logic          o_core_rvalid,
  output logic [31:0]   o_core_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_data,
  output logic          o_mem_wren,
  output logic [3:0]    o_mem_byteena,
  input  logic [31:0]   i_mem_q
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [0:0] OWN_CORE = 1'b0;
  localparam logic [0:0] OWN_HOST = 1'b1;

  logic [CW-1:0]     host_wait_cnt;
  logic              force_host;
  logic              host_win;
  logic              core_win;
  logic              rd_gnt_p0;
  logic [AW-1:0]     addr_hold;
  logic [31:0]       data_hold;
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] own_p;
  logic              rsp_vld;
  logic [31:0]       host_rdata_hold;
  logic [31:0]       core_rdata_hold;

`ifdef DMEM_ARB_RR_EN
  logic [0:0] last_winner;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      last_winner <= OWN_HOST;
    end else if (host_win) begin
      last_winner <= OWN_HOST;
    end else if (core_win) begin
      last_winner <= OWN_CORE;
    end
  end
`endif

  assign force_host = (host_wait_cnt == CW'(MAX_WAIT));

  // Grant decision: the starvation guard overrides either conflict policy.
  always_comb begin
    host_win = 1'b0;
    core_win = 1'b0;
    if (!i_Rst) begin
      if (i_host_req && i_core_req) begin
`ifdef DMEM_ARB_RR_EN
        host_win = force_host || (last_winner == OWN_CORE);
`else
        host_win = force_host;
`endif
        core_win = !host_win;
      end else begin
        host_win = i_host_req;
        core_win = i_core_req;
      end
    end
  end

  assign o_host_gnt = host_win;
  assign o_core_gnt = core_win;
  assign rd_gnt_p0  = (host_win && !i_host_we) || (core_win && !i_core_we);

  always_comb begin
    o_mem_addr    = addr_hold;
    o_mem_data    = data_hold;
    o_mem_wren    = 1'b0;
    o_mem_byteena = 4'b0000;
    if (host_win) begin
      o_mem_addr    = i_host_addr;
      o_mem_data    = i_host_wdata;
      o_mem_wren    = i_host_we;
      o_mem_byteena = i_host_we ? 4'b1111 : 4'b0000;
    end else if (core_win) begin
      o_mem_addr    = i_core_addr;
      o_mem_data    = i_core_wdata;
      o_mem_wren    = i_core_we;
      o_mem_byteena = i_core_we ? i_core_be : 4'b0000;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      addr_hold <= '0;
      data_hold <= '0;
    end else if (host_win || core_win) begin
      addr_hold <= o_mem_addr;
      data_hold <= o_mem_data;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      host_wait_cnt <= '0;
    end else if (!i_host_req || host_win) begin
      host_wait_cnt <= '0;
    end else if (!force_host) begin
      host_wait_cnt <= host_wait_cnt + CW'(1);
    end
  end

  // Stage p0 -> p[RD_LAT-1]: read ownership travels alongside the RAM latency.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      vld_p <= '0;
      own_p <= '0;
    end else begin
      vld_p[0] <= rd_gnt_p0;
      own_p[0] <= host_win;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        own_p[i] <= own_p[i-1];
      end
    end
  end

  assign rsp_vld       = vld_p[RD_LAT-1] && !i_Rst;
  assign o_host_rvalid = rsp_vld && own_p[RD_LAT-1];
  assign o_core_rvalid = rsp_vld && !own_p[RD_LAT-1];
  assign o_host_rdata  = o_host_rvalid ? i_mem_q : host_rdata_hold;
  assign o_core_rdata  = o_core_rvalid ? i_mem_q : core_rdata_hold;

  // Read data is presented live on the valid cycle and held afterwards.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      host_rdata_hold <= '0;
      core_rdata_hold <= '0;
    end else begin
      if (o_host_rvalid) host_rdata_hold <= i_mem_q;
      if (o_core_rvalid) core_rdata_hold <= i_mem_q;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a byte-enabled RAM model of matching read latency.
module tb_dmem_port_arbiter;

  localparam int AW       = 4;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_RR_EN
  localparam int T2_HOST_IDX = 0;
`else
  localparam int T2_HOST_IDX = MAX_WAIT;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [3:0]    core_be;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata, core_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data, mem_q;
  logic          mem_wren;
  logic [3:0]    mem_byteena;

  typedef struct packed {
    logic        host;
    logic [31:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] ram [16];
  logic [31:0] q1, q2;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
    .o_host_rdata(host_rdata),
    .i_core_req(core_req), .i_core_we(core_we), .i_core_be(core_be),
    .i_core_addr(core_addr), .i_core_wdata(core_wdata), .o_core_gnt(core_gnt),
    .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_wren(mem_wren),
    .o_mem_byteena(mem_byteena), .i_mem_q(mem_q)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  initial for (int i = 0; i < 16; i++) ram[i] = 32'h0;

  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= merge(ram[mem_addr], mem_data, mem_byteena);
    q1 <= ram[mem_addr];
    q2 <= q1;
  end
  assign mem_q = q2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (host_rvalid || core_rvalid) begin
      rsp_t e;
      if (host_rvalid && core_rvalid) chk("rvalid_both", 32'(1), 32'(0));
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rsp_owner", 32'(host_rvalid), 32'(e.host));
        chk("rsp_data", host_rvalid ? host_rdata : core_rdata, e.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    host_req = 1'b0;
    core_req = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic push, input logic [31:0] exp_rd);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    core_req = 1'b0;
    @(negedge clk);
    chk("host_gnt", 32'(host_gnt), 32'(1));
    chk("host_core_gnt", 32'(core_gnt), 32'(0));
    chk("host_mem_addr", 32'(mem_addr), 32'(a));
    chk("host_mem_wren", 32'(mem_wren), 32'(we));
    chk("host_mem_be", 32'(mem_byteena), we ? 32'hF : 32'h0);
    if (we) chk("host_mem_data", mem_data, wd);
    if (!we && push) exp_q.push_back('{host: 1'b1, data: exp_rd});
    next_cycle();
    host_req = 1'b0;
  endtask

  task automatic core_op(input logic we, input logic [3:0] be, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
    core_req = 1'b1; core_we = we; core_be = be; core_addr = a; core_wdata = wd;
    host_req = 1'b0;
    @(negedge clk);
    chk("core_gnt", 32'(core_gnt), 32'(1));
    chk("core_host_gnt", 32'(host_gnt), 32'(0));
    chk("core_mem_addr", 32'(mem_addr), 32'(a));
    chk("core_mem_wren", 32'(mem_wren), 32'(we));
    chk("core_mem_be", 32'(mem_byteena), we ? 32'(be) : 32'h0);
    if (we) chk("core_mem_data", mem_data, wd);
    else exp_q.push_back('{host: 1'b0, data: exp_rd});
    next_cycle();
    core_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    @(negedge clk);
    chk({tag, "_host_gnt"}, 32'(host_gnt), 32'(0));
    chk({tag, "_core_gnt"}, 32'(core_gnt), 32'(0));
    chk({tag, "_host_rvalid"}, 32'(host_rvalid), 32'(0));
    chk({tag, "_core_rvalid"}, 32'(core_rvalid), 32'(0));
    chk({tag, "_wren"}, 32'(mem_wren), 32'(0));
    chk({tag, "_byteena"}, 32'(mem_byteena), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic host_pending;
    logic hw;
    rst = 1'b1;
    host_req = 1'b1; host_we = 1'b1; host_addr = '0; host_wdata = '0;
    core_req = 1'b1; core_we = 1'b1; core_be = 4'hF; core_addr = '0; core_wdata = '0;
    next_cycle();
    next_cycle();
    // Requests present during reset must not be granted.
    chk_quiet("reset");
    next_cycle();
    rst = 1'b0;
    host_req = 1'b0; core_req = 1'b0;
    @(negedge clk);
    chk("reset_mem_addr", 32'(mem_addr), 32'(0));
    chk("reset_mem_data", mem_data, 32'h0);
    chk("reset_host_rdata", host_rdata, 32'h0);
    chk("reset_core_rdata", core_rdata, 32'h0);
    next_cycle();

    // Host write then read back.
    host_op(1'b1, 4'd3, 32'hCAFE0001, 1'b0, 32'h0);
    host_op(1'b0, 4'd3, 32'h0, 1'b1, 32'hCAFE0001);
    chk_quiet("idle");
    chk("idle_addr_hold", 32'(mem_addr), 32'(3));
    idle(4);

    // Core byte write over a full word, then read.
    core_op(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF, 32'h0);
    core_op(1'b1, 4'b0010, 4'd5, 32'h0000AB00, 32'h0);
    core_op(1'b0, 4'h0, 4'd5, 32'h0, 32'hFFFFABFF);
    idle(4);

    // Core streams reads while a host read waits for the starvation guard.
    host_pending = 1'b1;
    for (int i = 0; i < 20; i++) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 4'd5;
      host_req = host_pending; host_we = 1'b0; host_addr = 4'd3;
      @(negedge clk);
      hw = host_pending && (i == T2_HOST_IDX);
      chk("starve_host_gnt", 32'(host_gnt), 32'(hw));
      chk("starve_core_gnt", 32'(core_gnt), 32'(!hw));
      exp_q.push_back(hw ? '{host: 1'b1, data: 32'hCAFE0001} : '{host: 1'b0, data: 32'hFFFFABFF});
      next_cycle();
      if (hw) host_pending = 1'b0;
    end
    idle(4);

    // Reset right after a host read grant discards the in-flight response.
    host_op(1'b0, 4'd3, 32'h0, 1'b0, 32'h0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) chk_quiet("post_rst");
    chk("post_rst_host_rdata", host_rdata, 32'h0);
    chk("post_rst_core_rdata", core_rdata, 32'h0);
    chk("post_rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("post_rst_mem_data", mem_data, 32'h0);
    next_cycle();

    // Continuous conflict after reset.
    for (int i = 0; i < 6; i++) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 4'd5;
      host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      hw = (i % 2) == 1;
`else
      hw = 1'b0;
`endif
      chk("conflict_host_gnt", 32'(host_gnt), 32'(hw));
      chk("conflict_core_gnt", 32'(core_gnt), 32'(!hw));
      exp_q.push_back(hw ? '{host: 1'b1, data: 32'hCAFE0001} : '{host: 1'b0, data: 32'hFFFFABFF});
      next_cycle();
    end
    idle(4);

    // Interleaved reads from both owners on consecutive cycles.
    host_op(1'b1, 4'd1, 32'h11111111, 1'b0, 32'h0);
    core_op(1'b1, 4'hF, 4'd2, 32'h22222222, 32'h0);
    host_op(1'b0, 4'd1, 32'h0, 1'b1, 32'h11111111);
    core_op(1'b0, 4'h0, 4'd2, 32'h0, 32'h22222222);
    host_op(1'b0, 4'd3, 32'h0, 1'b1, 32'hCAFE0001);
    idle(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
